// File: rtl/multi_spi_wb_arbiter_pkg.sv
// Shared definitions for the multi-SPI Wishbone arbiter: FSM encoding and timeout sizing.
package multi_spi_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int TMO_W               = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 255;

endpackage

// File: rtl/multi_spi_wb_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module multi_spi_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int   c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
        any = found;
    end

endmodule

// File: rtl/multi_spi_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SPI subsystem slave port.
// Define MULTI_SPI_ARB_TIMEOUT_EN to enable the hung-slave timeout / bus-error abort.
module multi_spi_wb_arbiter
    import multi_spi_wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [3:0]                s_sel_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    input  logic                      s_ack_i,
    input  logic [31:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
        $error("NUM_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_t             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IW-1:0]          gidx, ptr, nxt;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   busy;

    multi_spi_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req (m_cyc_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign busy    = (state == ST_BUSY);
    assign nxt     = (gidx == IW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
    assign grant_o = grant;
    assign m_dat_o = s_dat_i;

    // Slave port follows the granted master only while BUSY; ABORT and IDLE park it low.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (busy) begin
            s_cyc_o = m_cyc_i[gidx];
            s_stb_o = m_stb_i[gidx];
            s_we_o  = m_we_i[gidx];
            s_sel_o = m_sel_i[4*gidx +: 4];
            s_adr_o = m_adr_i[32*gidx +: 32];
            s_dat_o = m_dat_i[32*gidx +: 32];
            m_ack_o = grant & {NUM_MASTERS{s_ack_i}};
        end
    end

`ifdef MULTI_SPI_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            tmo_cnt <= '0;
        else if (!busy || s_ack_i || !s_stb_o)
            tmo_cnt <= '0;
        else if (tmo_cnt != '1)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign m_err_o   = (state == ST_ABORT) ? grant : '0;
    assign timeout_o = (state == ST_ABORT);
`else
    assign m_err_o   = '0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_gnt;
                        gidx  <= pick_idx;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i[gidx]) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        ptr   <= nxt;
                    end
`ifdef MULTI_SPI_ARB_TIMEOUT_EN
                    // A late ack landing on the limit cycle wins over the abort.
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES) && !s_ack_i) begin
                        state <= ST_ABORT;
                        ptr   <= nxt;
                    end
`endif
                end
`ifdef MULTI_SPI_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
